// File: rtl/sort_pkg.sv
// Shared types and constants for the 10-entry 16-bit sorter and its result reader.
package sort_pkg;
  localparam int unsigned SORT_N          = 10;
  localparam int unsigned SORT_W          = 16;
  localparam int unsigned DEFAULT_TIMEOUT = 1024;

  typedef logic [SORT_W-1:0] sort_word_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    STREAM,
    FIN
  } rd_state_t;
endpackage

// File: rtl/sort_result_reader_if.sv
// Serial valid/ready result stream from the sort reader to a downstream consumer.
interface sort_result_reader_if #(
  parameter int unsigned W = 16
);
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_last;

  modport master (output dout, output dout_valid, output dout_last, input dout_ready);
  modport slave  (input dout, input dout_valid, input dout_last, output dout_ready);
endinterface

// File: rtl/sort_result_reader.sv
// Requests a sort, captures the ten result words on done and streams them out one per handshake.
// Optional ascending-order checker enabled by defining SORT_ORDER_CHECK_EN.
module sort_result_reader
  import sort_pkg::*;
#(
  parameter int unsigned N       = SORT_N,
  parameter int unsigned W       = SORT_W,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 rd_en,
  input  logic                 done,
  input  logic [W-1:0]         dat_in0,
  input  logic [W-1:0]         dat_in1,
  input  logic [W-1:0]         dat_in2,
  input  logic [W-1:0]         dat_in3,
  input  logic [W-1:0]         dat_in4,
  input  logic [W-1:0]         dat_in5,
  input  logic [W-1:0]         dat_in6,
  input  logic [W-1:0]         dat_in7,
  input  logic [W-1:0]         dat_in8,
  input  logic [W-1:0]         dat_in9,
  sort_result_reader_if.master out,
  output logic                 busy,
  output logic                 rd_done,
  output logic                 timeout,
  output logic                 order_err
);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(TIMEOUT);

  rd_state_t     state_q, state_d;
  logic [W-1:0]  din   [N];
  logic [W-1:0]  cap_q [N];
  logic [IW-1:0] idx_q;
  logic [CW-1:0] cnt_q;
  logic          timeout_q;
  logic          xfer;
  logic          at_last;
  logic          expired;
  logic          accept_start;

  always_comb begin
    din[0] = dat_in0;
    din[1] = dat_in1;
    din[2] = dat_in2;
    din[3] = dat_in3;
    din[4] = dat_in4;
    din[5] = dat_in5;
    din[6] = dat_in6;
    din[7] = dat_in7;
    din[8] = dat_in8;
    din[9] = dat_in9;
  end

  assign xfer         = (state_q == STREAM) && out.dout_ready;
  assign at_last      = (idx_q == IW'(N - 1));
  assign expired      = (cnt_q == CW'(TIMEOUT - 1));
  assign accept_start = (state_q == IDLE) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT: begin
        if (done)         state_d = STREAM;
        else if (expired) state_d = IDLE;
      end
      STREAM:  if (xfer && at_last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) cap_q[i] <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start) timeout_q <= 1'b0;
        REQ:  cnt_q <= '0;
        WAIT: begin
          if (done) begin
            cap_q <= din;
            idx_q <= '0;
          end else if (expired) begin
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STREAM: if (xfer && !at_last) idx_q <= idx_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign rd_en          = (state_q == REQ);
  assign busy           = (state_q != IDLE);
  assign rd_done        = (state_q == FIN);
  assign timeout        = timeout_q;
  assign out.dout_valid = (state_q == STREAM);
  assign out.dout_last  = (state_q == STREAM) && at_last;
  assign out.dout       = (state_q == STREAM) ? cap_q[idx_q] : '0;

`ifdef SORT_ORDER_CHECK_EN
  logic [W-1:0] prev_q;
  logic         order_err_q;

  // prev_q tracks the last word actually handed over, so stalls never compare a word with itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q      <= '0;
      order_err_q <= 1'b0;
    end else if (accept_start) begin
      order_err_q <= 1'b0;
    end else if (xfer) begin
      prev_q <= cap_q[idx_q];
      if (idx_q != '0 && cap_q[idx_q] < prev_q) order_err_q <= 1'b1;
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif
endmodule

// File: tb/tb_sort_result_reader.sv
// Self-checking bench for sort_result_reader: a sorter model plus a queue-based scoreboard of the expected stream.
module tb_sort_result_reader;
  import sort_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, done = 1'b0, start2 = 1'b0, done2 = 1'b0;
  logic rd_en, busy, rd_done, timeout, order_err;
  logic rd_en2, busy2, rd_done2, timeout2, order_err2;
  sort_word_t dat [10];

  sort_result_reader_if #(.W(SORT_W)) so  ();
  sort_result_reader_if #(.W(SORT_W)) so2 ();

  always #5 clk = ~clk;

  sort_result_reader dut (
    .clk(clk), .reset(reset), .start(start), .rd_en(rd_en), .done(done),
    .dat_in0(dat[0]), .dat_in1(dat[1]), .dat_in2(dat[2]), .dat_in3(dat[3]), .dat_in4(dat[4]),
    .dat_in5(dat[5]), .dat_in6(dat[6]), .dat_in7(dat[7]), .dat_in8(dat[8]), .dat_in9(dat[9]),
    .out(so), .busy(busy), .rd_done(rd_done), .timeout(timeout), .order_err(order_err)
  );

  sort_result_reader #(.TIMEOUT(16)) dut_to (
    .clk(clk), .reset(reset), .start(start2), .rd_en(rd_en2), .done(done2),
    .dat_in0(dat[0]), .dat_in1(dat[1]), .dat_in2(dat[2]), .dat_in3(dat[3]), .dat_in4(dat[4]),
    .dat_in5(dat[5]), .dat_in6(dat[6]), .dat_in7(dat[7]), .dat_in8(dat[8]), .dat_in9(dat[9]),
    .out(so2), .busy(busy2), .rd_done(rd_done2), .timeout(timeout2), .order_err(order_err2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  sort_word_t got   [$];
  logic       lasts [$];
  logic       oe    [$];
  int n_rden, n_rddone, n_unstable, post_busy;
  int rden_cyc, first_valid_cyc, first_acc_cyc, last_acc_cyc, rddone_cyc;

  // Sticky order flag expected after the k-th transfer: any descent among words 0..k.
  function automatic logic exp_oe(input sort_word_t v [10], input int k);
`ifdef SORT_ORDER_CHECK_EN
    for (int j = 1; j <= k; j++) if (v[j] < v[j-1]) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Sorter model and stream monitor; rmode 0 = ready high, 1 = toggling, 2 = random.
  task automatic run_read(input sort_word_t v [10], input int dly, input int rmode, input bit poke);
    bit fin = 0, held = 0, poked = 0, oe_pend = 0;
    sort_word_t hw = '0;
    got.delete(); lasts.delete(); oe.delete();
    n_rden = 0; n_rddone = 0; n_unstable = 0; post_busy = 0;
    rden_cyc = -1; first_valid_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1; rddone_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    if (poke) begin
      done = 1'b1;
      for (int i = 0; i < 10; i++) dat[i] = 16'hFFFF;
    end
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clk);
      start = poke && got.size() == 3 && !poked;
      if (start) poked = 1;
      if (poke && c == 1) done = 1'b0;
      if (rden_cyc >= 0 && c == rden_cyc + dly) begin
        done = 1'b1;
        for (int i = 0; i < 10; i++) dat[i] = v[i];
      end
      if (got.size() >= 1) begin
        done = 1'b0;
        for (int i = 0; i < 10; i++) dat[i] = 16'hDEAD;
      end
      case (rmode)
        0:       so.dout_ready = 1'b1;
        1:       so.dout_ready = c[0];
        default: so.dout_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (oe_pend) begin oe.push_back(order_err); oe_pend = 0; end
      if (rd_en) begin n_rden++; if (rden_cyc < 0) rden_cyc = c; end
      if (so.dout_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = c;
        if (held && so.dout !== hw) n_unstable++;
        if (so.dout_ready) begin
          got.push_back(so.dout);
          lasts.push_back(so.dout_last);
          if (first_acc_cyc < 0) first_acc_cyc = c;
          last_acc_cyc = c;
          held = 0;
          oe_pend = 1;
        end else begin
          held = 1;
          hw = so.dout;
        end
      end
      if (rd_done) begin n_rddone++; rddone_cyc = c; fin = 1; end
    end
    start = 1'b0;
    done  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (rd_en) n_rden++;
      if (busy) post_busy++;
      if (rd_done) n_rddone++;
    end
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({rd_en, so.dout_valid, so.dout_last, busy, rd_done, timeout, order_err, so.dout} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required all zero",
               {rd_en, so.dout_valid, so.dout_last, busy, rd_done, timeout, order_err, so.dout});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic_stream;
    sort_word_t v [10];
    for (int i = 0; i < 10; i++) v[i] = sort_word_t'(i + 1);
    run_read(v, 20, 0, 0);
    n_checks++;
    if (n_rden !== 1) begin n_fail++; $display("FAIL basic_rd_en_count: got %0d required 1", n_rden); end
    n_checks++;
    if (got.size() !== 10) begin n_fail++; $display("FAIL basic_word_count: got %0d required 10", got.size()); end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      n_checks++;
      if (got[i] !== v[i] || lasts[i] !== (i == 9)) begin
        n_fail++;
        $display("FAIL basic_word%0d: got %h last=%b required %h last=%b", i, got[i], lasts[i], v[i], i == 9);
      end
      n_checks++;
      if (oe[i] !== 1'b0) begin n_fail++; $display("FAIL basic_order_err%0d: got %b required 0", i, oe[i]); end
    end
    n_checks++;
    if (first_valid_cyc !== 21) begin n_fail++; $display("FAIL basic_first_valid_cycle: got %0d required 21", first_valid_cyc); end
    n_checks++;
    if (last_acc_cyc - first_acc_cyc !== 9) begin
      n_fail++; $display("FAIL basic_throughput: got span %0d required 9", last_acc_cyc - first_acc_cyc);
    end
    n_checks++;
    if (rddone_cyc !== last_acc_cyc + 1 || n_rddone !== 1 || post_busy !== 0) begin
      n_fail++;
      $display("FAIL basic_rd_done: got cycle %0d count %0d busy_after %0d required cycle %0d count 1 busy_after 0",
               rddone_cyc, n_rddone, post_busy, last_acc_cyc + 1);
    end
  endtask

  task automatic test_backpressure;
    sort_word_t v [10];
    for (int i = 0; i < 10; i++) v[i] = sort_word_t'(16'h0005 + i);
    run_read(v, 7, 1, 0);
    n_checks++;
    if (got.size() !== 10 || n_unstable !== 0) begin
      n_fail++; $display("FAIL bp_count_stable: got %0d words %0d unstable required 10 words 0 unstable", got.size(), n_unstable);
    end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      n_checks++;
      if (got[i] !== v[i]) begin n_fail++; $display("FAIL bp_word%0d: got %h required %h", i, got[i], v[i]); end
    end
  endtask

  task automatic test_random;
    sort_word_t v [10];
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) v[i] = sort_word_t'($urandom);
      run_read(v, int'($urandom_range(1, 40)), 2, 0);
      n_checks++;
      if (got.size() !== 10 || n_unstable !== 0 || n_rddone !== 1) begin
        n_fail++;
        $display("FAIL rand%0d_stream: got %0d words %0d unstable %0d rd_done required 10 0 1", r, got.size(), n_unstable, n_rddone);
      end
      for (int i = 0; i < got.size() && i < 10; i++) begin
        n_checks++;
        if (got[i] !== v[i] || lasts[i] !== (i == 9) || oe[i] !== exp_oe(v, i)) begin
          n_fail++;
          $display("FAIL rand%0d_word%0d: got %h last=%b oe=%b required %h last=%b oe=%b",
                   r, i, got[i], lasts[i], oe[i], v[i], i == 9, exp_oe(v, i));
        end
      end
    end
  endtask

  task automatic test_ignored_inputs;
    sort_word_t v [10];
    for (int i = 0; i < 10; i++) v[i] = sort_word_t'(16'h0100 * (i + 1));
    run_read(v, 6, 0, 1);
    n_checks++;
    if (n_rden !== 1 || n_rddone !== 1 || post_busy !== 0) begin
      n_fail++; $display("FAIL ignored_rd_en: got %0d rd_en %0d rd_done %0d busy_after required 1 1 0", n_rden, n_rddone, post_busy);
    end
    n_checks++;
    if (got.size() !== 10) begin n_fail++; $display("FAIL ignored_word_count: got %0d required 10", got.size()); end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      n_checks++;
      if (got[i] !== v[i]) begin n_fail++; $display("FAIL ignored_word%0d: got %h required %h", i, got[i], v[i]); end
    end
  endtask

  task automatic test_timeout;
    int t_cyc = -1, nv = 0, nd = 0;
    @(negedge clk);
    start2 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      #1;
      if (timeout2 && t_cyc < 0) begin
        t_cyc = c;
        n_checks++;
        if (busy2 !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got busy %b required 0", busy2); end
      end
      if (so2.dout_valid) nv++;
      if (rd_done2) nd++;
    end
    n_checks++;
    if (t_cyc !== 17) begin n_fail++; $display("FAIL timeout_cycle: got %0d required 17", t_cyc); end
    n_checks++;
    if (nv !== 0 || nd !== 0) begin n_fail++; $display("FAIL timeout_no_stream: got %0d valid %0d rd_done required 0 0", nv, nd); end
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    #1;
    n_checks++;
    if (timeout2 !== 1'b0 || busy2 !== 1'b1) begin
      n_fail++; $display("FAIL timeout_clear: got timeout %b busy %b required 0 1", timeout2, busy2);
    end
  endtask

  task automatic test_reset_mid;
    sort_word_t v [10];
    int acc = 0;
    for (int i = 0; i < 10; i++) v[i] = sort_word_t'(16'h0A00 + i);
    @(negedge clk);
    start = 1'b1;
    so.dout_ready = 1'b1;
    for (int c = 0; c < 100 && acc < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 5) begin done = 1'b1; for (int i = 0; i < 10; i++) dat[i] = v[i]; end
      #1;
      if (so.dout_valid && so.dout_ready) acc++;
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (acc !== 4 || {rd_en, so.dout_valid, so.dout_last, busy, rd_done, timeout, order_err, so.dout} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got accepted %0d outputs %b required accepted 4 outputs zero", acc,
               {rd_en, so.dout_valid, so.dout_last, busy, rd_done, timeout, order_err, so.dout});
    end
    done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) v[i] = sort_word_t'(16'h0B00 + i);
    run_read(v, 4, 0, 0);
    n_checks++;
    if (got.size() !== 10 || n_rden !== 1 || n_rddone !== 1) begin
      n_fail++; $display("FAIL reset_rerun: got %0d words %0d rd_en %0d rd_done required 10 1 1", got.size(), n_rden, n_rddone);
    end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      n_checks++;
      if (got[i] !== v[i]) begin n_fail++; $display("FAIL reset_rerun_word%0d: got %h required %h", i, got[i], v[i]); end
    end
  endtask

  task automatic test_order_check;
    sort_word_t v [10];
    v[0] = 16'd3; v[1] = 16'd3; v[2] = 16'd7; v[3] = 16'd2; v[4] = 16'd9;
    for (int i = 5; i < 10; i++) v[i] = sort_word_t'(16'd10 + i);
    run_read(v, 3, 0, 0);
    n_checks++;
    if (oe.size() !== 10) begin n_fail++; $display("FAIL order_samples: got %0d required 10", oe.size()); end
    for (int i = 0; i < oe.size() && i < 10; i++) begin
      n_checks++;
      if (oe[i] !== exp_oe(v, i)) begin n_fail++; $display("FAIL order_err%0d: got %b required %b", i, oe[i], exp_oe(v, i)); end
    end
    for (int i = 0; i < 10; i++) v[i] = sort_word_t'(16'd20 * i);
    run_read(v, 3, 0, 0);
    n_checks++;
    if (oe.size() < 1 || oe[0] !== 1'b0) begin
      n_fail++; $display("FAIL order_clear: got %b required 0", oe.size() > 0 ? oe[0] : 1'bx);
    end
  endtask

  initial begin
    so.dout_ready  = 1'b1;
    so2.dout_ready = 1'b1;
    for (int i = 0; i < 10; i++) dat[i] = '0;
    test_reset;
    test_basic_stream;
    test_backpressure;
    test_random;
    test_ignored_inputs;
    test_timeout;
    test_reset_mid;
    test_order_check;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
